// File: rtl/delay_sum_scanner.sv
// delay_sum_scanner: delay-and-sum beamformer pixel scanner.
// Walks an 80x60 pixel grid row-major. For each pixel it latches the
// per-mic delays, fetches one delayed sample per microphone from the
// sample RAM and accumulates them. The beam power is then offered on a
// valid/ready result channel.
// Build option: define BEAM_SQUARE_EN to output (sum>>>4)^2 instead of |sum|.
module delay_sum_scanner #(
  parameter int DATA_W = 16,  // sample width
  parameter int COEF_W = 8,   // delay / buffer index width
  parameter int STAGES = 16   // number of microphone channels summed
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [COEF_W-1:0]              i_wr_ptr,
  output logic signed [6:0]              o_p_x,
  output logic signed [5:0]              o_p_y,
  input  logic [STAGES-1:0][COEF_W-1:0]  i_delta,
  output logic                           o_rd_en,
  output logic [$clog2(STAGES)-1:0]      o_rd_mic,
  output logic [COEF_W-1:0]              o_rd_addr,
  input  logic signed [DATA_W-1:0]       i_rd_data,
  output logic                           o_pix_valid,
  output logic [31:0]                    o_pix_data,
  output logic [6:0]                     o_pix_col,
  output logic [5:0]                     o_pix_row,
  input  logic                           i_pix_ready,
  output logic                           o_busy,
  output logic                           o_frame_done
);

  localparam int MIC_W = $clog2(STAGES);
  localparam int ACC_W = DATA_W + MIC_W;
  localparam int COLS  = 80;
  localparam int ROWS  = 60;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [6:0]                r_col;
  logic [5:0]                r_row;
  logic [COEF_W-1:0]         r_wr_ptr;
  logic [COEF_W-1:0]         r_delta [STAGES];
  logic [MIC_W-1:0]          r_mic;
  logic                      r_rd_vld_p1;
  logic signed [ACC_W-1:0]   r_acc_p1;
  logic                      r_pix_valid;
  logic [31:0]               r_pix_data;
  logic [6:0]                r_pix_col;
  logic [5:0]                r_pix_row;
  logic                      r_frame_done;
  logic                      w_rd_en;
  logic                      w_busy;
  logic                      w_last_mic;
  logic                      w_last_col;
  logic                      w_last_row;
  logic signed [ACC_W-1:0]   w_sample_ext;
  logic signed [ACC_W-1:0]   w_sum_p1;

  // Magnitude of the beam sum, zero-extended; 20 bits always holds it.
  function automatic logic [31:0] f_abs(input logic signed [ACC_W-1:0] s);
    logic [ACC_W-1:0] mag;
    mag = s[ACC_W-1] ? $unsigned(-s) : $unsigned(s);
    return {{(32-ACC_W){1'b0}}, mag};
  endfunction

`ifdef BEAM_SQUARE_EN
  // Power estimate: scale the sum back to sample width, then square.
  function automatic logic [31:0] f_square(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0]    t;
    logic signed [DATA_W-1:0]   q;
    logic signed [2*DATA_W-1:0] p;
    t = s >>> MIC_W;
    q = t[DATA_W-1:0];
    p = q * q;
    return $unsigned(p);
  endfunction
`endif

  assign w_last_mic   = (r_mic == MIC_W'(STAGES - 1));
  assign w_last_col   = (r_col == 7'(COLS - 1));
  assign w_last_row   = (r_row == 6'(ROWS - 1));
  assign w_sample_ext = {{(ACC_W-DATA_W){i_rd_data[DATA_W-1]}}, i_rd_data};
  assign w_sum_p1     = r_acc_p1 + w_sample_ext;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LATCH;
      S_LATCH: w_next = S_READ;
      S_READ:  if (w_last_mic) w_next = S_DRAIN;
      S_DRAIN: w_next = S_OUT;
      S_OUT:   if (i_pix_ready) w_next = (w_last_col && w_last_row) ? S_IDLE : S_LATCH;
      default: w_next = S_IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    w_rd_en = (r_state == S_READ);
    w_busy  = (r_state != S_IDLE);
  end

  // Control: pixel position, read sequencing, handshake and frame pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_wr_ptr     <= '0;
      r_mic        <= '0;
      r_rd_vld_p1  <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_rd_vld_p1  <= w_rd_en;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_wr_ptr <= i_wr_ptr;
            r_col    <= '0;
            r_row    <= '0;
          end
        end
        S_LATCH: r_mic <= '0;
        S_READ:  r_mic <= r_mic + MIC_W'(1);
        S_DRAIN: r_pix_valid <= 1'b1;
        S_OUT: begin
          if (i_pix_ready) begin
            r_pix_valid <= 1'b0;
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) begin
                r_row        <= '0;
                r_frame_done <= 1'b1;
              end else begin
                r_row <= r_row + 6'd1;
              end
            end else begin
              r_col <= r_col + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Delay capture for the current pixel (delta generator settles by LATCH).
  always_ff @(posedge i_clk) begin
    if (r_state == S_LATCH) begin
      for (int m = 0; m < STAGES; m++) r_delta[m] <= i_delta[m];
    end
  end

  // ---- stage p1: sample returned one cycle after each read request ----
  // Accumulate returned samples; cleared at the start of each pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst)                    r_acc_p1 <= '0;
    else if (r_state == S_LATCH)  r_acc_p1 <= '0;
    else if (r_rd_vld_p1)         r_acc_p1 <= w_sum_p1;
  end

  // ---- stage p2: result registers, loaded with the final (16th) sample folded in ----
  // Result capture in DRAIN; held through OUT until the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_data <= '0;
      r_pix_col  <= '0;
      r_pix_row  <= '0;
    end else if (r_state == S_DRAIN) begin
`ifdef BEAM_SQUARE_EN
      r_pix_data <= f_square(w_sum_p1);
`else
      r_pix_data <= f_abs(w_sum_p1);
`endif
      r_pix_col  <= r_col;
      r_pix_row  <= r_row;
    end
  end

  assign o_p_x        = $signed(r_col - 7'd40);
  assign o_p_y        = $signed(r_row - 6'd30);
  assign o_rd_en      = w_rd_en;
  assign o_rd_mic     = r_mic;
  assign o_rd_addr    = r_wr_ptr - r_delta[r_mic];
  assign o_pix_valid  = r_pix_valid;
  assign o_pix_data   = r_pix_data;
  assign o_pix_col    = r_pix_col;
  assign o_pix_row    = r_pix_row;
  assign o_busy       = w_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_delay_sum_scanner.sv
// Testbench for delay_sum_scanner: sample RAM and delta generator models,
// table vectors, multi-cycle corner sequences, randomized run, full frame.
module tb_delay_sum_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               ready = 1'b0;
  logic [7:0]         wr_ptr = 8'd0;
  logic [15:0][7:0]   delta;
  logic signed [15:0] rd_data = 16'sd0;
  logic signed [6:0]  p_x;
  logic signed [5:0]  p_y;
  logic               rd_en;
  logic [3:0]         rd_mic;
  logic [7:0]         rd_addr;
  logic               pix_valid;
  logic [31:0]        pix_data;
  logic [6:0]         pix_col;
  logic [5:0]         pix_row;
  logic               busy;
  logic               frame_done;

  delay_sum_scanner dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_wr_ptr(wr_ptr),
    .o_p_x(p_x), .o_p_y(p_y), .i_delta(delta),
    .o_rd_en(rd_en), .o_rd_mic(rd_mic), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_pix_col(pix_col), .o_pix_row(pix_row),
    .i_pix_ready(ready), .o_busy(busy), .o_frame_done(frame_done)
  );

  // Sample memory per mic and delay law: delta = base + x*kx + y*ky (mod 256).
  int mem [16][256];
  int base [16];
  int kx [16];
  int ky [16];

  always_comb begin
    delta = '0;
    for (int m = 0; m < 16; m++)
      delta[m] = 8'((base[m] + int'(p_x) * kx[m] + int'(p_y) * ky[m]) & 255);
  end

  int n_tests = 0, n_fail = 0, cyc = 0;
  int wr_lat = 0;
  bit mon_en = 0, chk_space = 0;
  int hs_cnt = 0, last_hs_cyc = -1, exp_col = 0, exp_row = 0;
  int fd_cnt = 0, fd_cyc = -1;
  logic [31:0] hs_data = 0;
  int hs_col = 0, hs_row = 0;
  bit pend_v = 0;
  int pend_mic = 0, pend_addr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Expected pixel value from the delay-and-sum definition.
  function automatic longint model_pix(input int col, input int row);
    int s = 0;
    int px = col - 40;
    int py = row - 30;
    for (int m = 0; m < 16; m++) begin
      int d = (base[m] + px * kx[m] + py * ky[m]) & 255;
      s += mem[m][(wr_lat - d) & 255];
    end
`ifdef BEAM_SQUARE_EN
    begin
      int q = s >>> 4;
      return longint'(q) * longint'(q);
    end
`else
    return (s < 0) ? -s : s;
`endif
  endfunction

  // One clock: note a handshake at the coming edge, then service the RAM.
  task automatic tick();
    if (pix_valid && ready && !rst) begin
      hs_cnt++;
      hs_data = pix_data;
      hs_col  = int'(pix_col);
      hs_row  = int'(pix_row);
      if (mon_en) begin
        check($sformatf("pix_pos_%0d_%0d", exp_col, exp_row), hs_col * 100 + hs_row, exp_col * 100 + exp_row);
        check($sformatf("pix_data_%0d_%0d", exp_col, exp_row), {32'd0, pix_data}, model_pix(exp_col, exp_row));
        if (chk_space && last_hs_cyc >= 0) check("spacing", cyc - last_hs_cyc, 19);
        if (exp_col == 79) begin
          exp_col = 0;
          exp_row = (exp_row == 59) ? 0 : exp_row + 1;
        end else exp_col++;
      end
      last_hs_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (pend_v) rd_data = 16'(mem[pend_mic][pend_addr]);
    else        rd_data = 16'($urandom);
    pend_v    = rd_en;
    pend_mic  = int'(rd_mic);
    pend_addr = int'(rd_addr);
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    if (chk) begin
      check("rst_rd_en", rd_en, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_pix_col", pix_col, 0);
      check("rst_pix_row", pix_row, 0);
      check("rst_p_x", int'(p_x), -40);
      check("rst_p_y", int'(p_y), -30);
    end
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] wp);
    wr_ptr = wp;
    if (!busy) begin
      wr_lat = int'(wp); exp_col = 0; exp_row = 0; last_hs_cyc = -1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_ptr = 8'($urandom);
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int k = 0;
    while (hs_cnt < target && k < budget) begin tick(); k++; end
    check(name, hs_cnt >= target, 1);
  endtask

  task automatic randomize_scene();
    for (int m = 0; m < 16; m++) begin
      base[m] = $urandom_range(0, 255);
      kx[m]   = $urandom_range(0, 6) - 3;
      ky[m]   = $urandom_range(0, 6) - 3;
      for (int a = 0; a < 256; a++) mem[m][a] = $urandom_range(0, 65535) - 32768;
    end
  endtask

  typedef struct {
    logic [7:0] wp;
    logic [7:0] d0;
    int         lo;
    int         hi;
    logic [7:0] exp_addr;
    longint     exp_abs;
    longint     exp_sq;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int h0, k, viol;
    bit pulsed;
    longint expv;

    tbl[0] = '{8'd5,   8'd147, -100,   40,     8'd114, 480,    900};
    tbl[1] = '{8'd200, 8'd0,   1,      1,      8'd200, 16,     1};
    tbl[2] = '{8'd0,   8'd1,   32767,  32767,  8'd255, 524272, 1073676289};
    tbl[3] = '{8'd255, 8'd255, -32768, -32768, 8'd0,   524288, 1073741824};
    tbl[4] = '{8'd10,  8'd10,  300,    -1000,  8'd0,   5600,   122500};
    tbl[5] = '{8'd128, 8'd200, -7,     8,      8'd184, 8,      0};

    for (int m = 0; m < 16; m++) begin
      base[m] = 0; kx[m] = 0; ky[m] = 0;
      for (int a = 0; a < 256; a++) mem[m][a] = 0;
    end

    do_reset(1);

    // Table vectors: first-pixel read address and result.
    for (int i = 0; i < 6; i++) begin
      for (int m = 0; m < 16; m++) begin
        base[m] = (m == 0) ? int'(tbl[i].d0) : m * 17;
        kx[m] = 0; ky[m] = 0;
        for (int a = 0; a < 256; a++) mem[m][a] = (m < 8) ? tbl[i].lo : tbl[i].hi;
      end
      do_reset(0);
      mon_en = 0; chk_space = 0; ready = 1'b1;
      pulse_start(tbl[i].wp);
      k = 0;
      while (!rd_en && k < 10) begin tick(); k++; end
      check($sformatf("vec%0d_first_rd", i), {rd_en, rd_mic}, {1'b1, 4'd0});
      check($sformatf("vec%0d_addr", i), rd_addr, tbl[i].exp_addr);
      h0 = hs_cnt;
      wait_hs(h0 + 1, 40, $sformatf("vec%0d_hs_timeout", i));
`ifdef BEAM_SQUARE_EN
      expv = tbl[i].exp_sq;
`else
      expv = tbl[i].exp_abs;
`endif
      check($sformatf("vec%0d_data", i), {32'd0, hs_data}, expv);
    end

    // Backpressure: hold ready low on pixel (3,0).
    randomize_scene();
    do_reset(0);
    mon_en = 1; chk_space = 0; ready = 1'b1;
    pulse_start(8'($urandom));
    h0 = hs_cnt;
    wait_hs(h0 + 3, 100, "stall_reach");
    ready = 1'b0;
    k = 0;
    while (!pix_valid && k < 40) begin tick(); k++; end
    check("stall_valid_seen", pix_valid, 1);
    begin
      logic [31:0] cap;
      cap = pix_data;
      for (int t = 0; t < 10; t++) begin
        check("stall_valid", pix_valid, 1);
        check("stall_data", pix_data, cap);
        check("stall_col", pix_col, 3);
        check("stall_p_x", int'(p_x), -37);
        tick();
      end
    end
    check("stall_no_advance", hs_cnt, h0 + 3);
    ready = 1'b1;
    tick();
    check("stall_release", hs_cnt * 1000 + hs_col, (h0 + 4) * 1000 + 3);
    wait_hs(h0 + 5, 40, "stall_next");
    check("stall_next_col", hs_col, 4);

    // Reset in the middle of READ for pixel 10.
    randomize_scene();
    do_reset(0);
    ready = 1'b1;
    pulse_start(8'($urandom));
    h0 = hs_cnt;
    wait_hs(h0 + 10, 300, "rst_reach_p10");
    k = 0;
    while (!(rd_en && rd_mic == 4'd5) && k < 30) begin tick(); k++; end
    check("rst_mid_read_seen", rd_en, 1);
    rst = 1'b1;
    tick();
    check("rst_mid_rd_en", rd_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", pix_valid, 0);
    rst = 1'b0;
    viol = 0;
    for (int t = 0; t < 25; t++) begin
      tick();
      if (pix_valid || busy || rd_en) viol++;
    end
    check("rst_quiet", viol, 0);
    pulse_start(8'($urandom));
    h0 = hs_cnt;
    wait_hs(h0 + 1, 40, "rst_restart");
    check("rst_restart_pos", hs_col * 100 + hs_row, 0);

    // Randomized run with random backpressure and ignored start pulses.
    randomize_scene();
    do_reset(0);
    ready = 1'b1;
    pulse_start(8'($urandom));
    h0 = hs_cnt;
    k = 0;
    while (hs_cnt < h0 + 60 && k < 4000) begin
      ready  = ($urandom_range(0, 9) < 7);
      start  = busy && ($urandom_range(0, 40) == 0);
      wr_ptr = 8'($urandom);
      tick();
      k++;
    end
    start = 1'b0;
    check("rand_reach", hs_cnt >= h0 + 60, 1);

    // Full frame, all samples 1, ready high, one ignored start mid-frame.
    for (int m = 0; m < 16; m++) begin
      base[m] = $urandom_range(0, 255);
      kx[m] = $urandom_range(0, 4) - 2;
      ky[m] = $urandom_range(0, 4) - 2;
      for (int a = 0; a < 256; a++) mem[m][a] = 1;
    end
    do_reset(0);
    ready = 1'b1; chk_space = 1;
    pulse_start(8'($urandom));
    fd_cnt = 0;
    h0 = hs_cnt;
    k = 0; pulsed = 0;
    while (fd_cnt == 0 && k < 4800 * 19 + 200) begin
      start = !pulsed && (hs_cnt - h0 >= 2000) && busy;
      if (start) begin pulsed = 1; wr_ptr = 8'($urandom); end
      tick();
      k++;
    end
    start = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    check("frame_pixels", hs_cnt - h0, 4800);
    check("frame_done_count", fd_cnt, 1);
    check("frame_done_timing", fd_cyc, last_hs_cyc + 1);
    check("frame_idle", busy, 0);
    check("frame_no_valid", pix_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
